// File: rtl/spi_flash_word_reader.sv
// rtl/spi_flash_word_reader.sv - Fetches one big-endian 32-bit word from SPI NOR flash with READ (0x03)
module spi_flash_word_reader #(
   parameter logic [7:0] CMD_READ        = 8'h03,
   parameter int         CS_SETUP_CYCLES = 2,
   parameter int         CS_HOLD_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic [23:0] addr,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        spi_start,
   output logic [7:0]  spi_data_in,
   input  logic        spi_done,
   input  logic [7:0]  spi_data_out,
   output logic        spi_cs_n
);

   localparam int CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      START,
      WAIT_DONE,
      RELEASE,
      CS_HOLD,
      FINISH
   } state_t;

   state_t           state;
   logic [23:0]      addr_q;
   logic [2:0]       byte_idx;
   logic [CNT_W-1:0] cnt;

   // Byte sequence on MOSI: command, 24-bit address MSB first, then dummy bytes while data shifts in.
   function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [23:0] a);
      case (idx)
         3'd0:    return CMD_READ;
         3'd1:    return a[23:16];
         3'd2:    return a[15:8];
         3'd3:    return a[7:0];
         default: return 8'h00;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         addr_q      <= '0;
         byte_idx    <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         rdata       <= '0;
         spi_start   <= 1'b0;
         spi_data_in <= '0;
         spi_cs_n    <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // The done cycle itself still counts as busy for a new request.
               if (req && !done) begin
                  addr_q   <= addr;
                  busy     <= 1'b1;
                  spi_cs_n <= 1'b0;
                  byte_idx <= '0;
                  cnt      <= '0;
                  state    <= CS_SETUP;
               end
            end
            CS_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt   <= '0;
                  state <= START;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            START: begin
               spi_data_in <= tx_byte(byte_idx, addr_q);
               spi_start   <= 1'b1;
               state       <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (spi_done) begin
                  spi_start <= 1'b0;
                  if (byte_idx[2]) begin
                     case (byte_idx[1:0])
                        2'd0:    rdata[31:24] <= spi_data_out;
                        2'd1:    rdata[23:16] <= spi_data_out;
                        2'd2:    rdata[15:8]  <= spi_data_out;
                        default: rdata[7:0]   <= spi_data_out;
                     endcase
                  end
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               // Never restart the engine until it has withdrawn done for the previous byte.
               if (!spi_done) begin
                  if (byte_idx == 3'd7) begin
                     spi_cs_n <= 1'b1;
                     cnt      <= '0;
                     state    <= CS_HOLD;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     state    <= START;
                  end
               end
            end
            CS_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt   <= '0;
                  state <= FINISH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_flash_word_reader.md
# spi_flash_word_reader

Sequencer that sits directly upstream of the SPI byte engine and fetches one 32-bit big-endian word from a serial NOR flash using the standard READ (0x03) command. It owns chip select, drives the byte engine's start/data_in handshake for each of 8 bytes (command, 3 address bytes, 4 data bytes), and assembles the received bytes into a word. It is used by the boot/ROM path and by memory-mapped flash reads.

## Interface
- CMD_READ, 8'h03, command byte sent first
- CS_SETUP_CYCLES, 2, clk cycles cs_n is low before the first byte starts (≥1)
- CS_HOLD_CYCLES, 2, clk cycles cs_n stays high after a transaction before busy drops (≥1)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  start a word read; sampled only in IDLE
- addr  in  24  byte address; latched on accepted req
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse; rdata valid in that cycle and held afterwards
- rdata  out  32  read word; first received byte in [31:24]
- spi_start  out  1  byte-engine start, level-held per the handshake below
- spi_data_in  out  8  byte to transmit
- spi_done  in  1  byte-engine completion, high until spi_start drops
- spi_data_out  in  8  byte received
- spi_cs_n  out  1  flash chip select, active low

## Operation
- All outputs registered. Reset values: busy=0, done=0, rdata=0, spi_start=0, spi_data_in=0, spi_cs_n=1. The FSM and counters go to IDLE/0.
- States: IDLE, CS_SETUP, START, WAIT_DONE, RELEASE, CS_HOLD, FINISH.
- IDLE: when req=1, latch addr, set busy=1, spi_cs_n=0, byte_idx=0, and go to CS_SETUP. req=0 or busy: no action. req during busy is ignored, with no queueing.
- CS_SETUP: count CS_SETUP_CYCLES, then go to START.
- START: drive spi_data_in = byte_idx 0: CMD_READ; 1: addr[23:16]; 2: addr[15:8]; 3: addr[7:0]; 4–7: 8'h00. Set spi_start=1 and go to WAIT_DONE.
- WAIT_DONE: hold spi_start=1 and spi_data_in stable until spi_done=1 is sampled.
  - Then drop spi_start.
  - For byte_idx≥4, store spi_data_out into rdata[31-8*(byte_idx-4) -: 8].
  - Go to RELEASE.
- RELEASE: wait until spi_done=0 is sampled. Then, if byte_idx==7, go to CS_HOLD with spi_cs_n=1. Otherwise increment byte_idx and go to START.
- CS_HOLD: count CS_HOLD_CYCLES, then go to FINISH.
- FINISH: pulse done=1, set busy=0, and go to IDLE. A req in the cycle done is high is not accepted. The next req is accepted from the following cycle.
- rdata is written only during bytes 4–7. Intermediate values are not valid until done.
- byte_idx is 3 bits and never wraps within a transaction.
- Reset asserted mid-transaction: spi_start and busy fall and spi_cs_n rises asynchronously, with no done pulse. The byte engine is reset from the same source.

## Timing
- req accepted at edge E0: busy=1 and spi_cs_n=0 are visible after E0.
- spi_start first rises CS_SETUP_CYCLES+1 edges after E0.
- Per byte: spi_start rises 1 cycle after entering START, drops 1 cycle after spi_done is sampled high, and re-rises at the earliest 2 cycles after spi_done is sampled low. spi_start is never high while spi_done is high from the previous byte.
- spi_cs_n is low from E0 until the edge after the last spi_done low is sampled.
- done occurs CS_HOLD_CYCLES+1 edges after spi_cs_n rises. busy falls on the same edge as done.
- Total latency with an engine of fixed byte time T (start-to-done) and 1-cycle done release ≈ CS_SETUP+1 + 8·(T+3) + CS_HOLD+1 cycles.

## Test plan
- Reset: hold reset_n=0 mid-clock → all outputs at their reset values immediately, without waiting for a clock edge.
- Basic read: behavioural flash model, req with addr=24'h012345, flash returns DE AD BE EF → transmitted bytes are 03 01 23 45 00 00 00 00; done pulses once with rdata=32'hDEADBEEF; spi_cs_n is low for exactly the 8-byte span.
- Handshake: the engine model delays spi_done by a random 5–40 cycles and holds it until start drops → spi_start never re-rises while spi_done=1, and spi_data_in is stable whenever spi_start=1.
- Back-to-back and ignored req: req held high continuously for two reads (addr 0x000000, then 0xFFFFFC) → two separate transactions; spi_cs_n is high for at least CS_HOLD_CYCLES between them; req pulses during busy are not counted.
- Reset mid-transaction: assert reset_n=0 during byte 5 → spi_cs_n=1, busy=0, no done pulse. A subsequent read of 24'h000100 returns the correct word.
- Parameters: CS_SETUP_CYCLES=1 and CS_HOLD_CYCLES=5 → measured cs-setup and cs-hold intervals match the Timing section exactly.
